// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder; one full-adder slice, LSB first,
//            registered carry, parallel registered result with done pulse.
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int            CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;

    logic [1:0]       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_sa, w_sa_nxt;
    logic [WIDTH-1:0] r_sb, w_sb_nxt;
    logic [WIDTH-1:0] r_sr, w_sr_nxt;
    logic             r_c, w_c_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt, w_busy_nxt, w_done_nxt;

    // Full-adder slice on the current LSB pair and the registered carry
    logic             w_s, w_co;
    logic [WIDTH-1:0] w_sr_shift;

    always_comb begin
        w_s  = r_sa[0] ^ r_sb[0] ^ r_c;
        w_co = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_c) | (r_sb[0] & r_c);
        // Shift-then-overwrite keeps the WIDTH=1 case free of empty slices
        w_sr_shift            = r_sr >> 1;
        w_sr_shift[WIDTH-1]   = w_s;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= C_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_sr    <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sa    <= w_sa_nxt;
            r_sb    <= w_sb_nxt;
            r_sr    <= w_sr_nxt;
            r_c     <= w_c_nxt;
            r_cnt   <= w_cnt_nxt;
            sum     <= w_sum_nxt;
            cout    <= w_cout_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sa_nxt    = r_sa;
        w_sb_nxt    = r_sb;
        w_sr_nxt    = r_sr;
        w_c_nxt     = r_c;
        w_cnt_nxt   = r_cnt;
        w_sum_nxt   = sum;
        w_cout_nxt  = cout;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;

        case (r_state)
            C_IDLE, C_DONE: begin
                // DONE accepts a start exactly like IDLE for gap-free streaming
                if (start) begin
                    w_sa_nxt    = a;
                    w_sb_nxt    = b;
                    w_c_nxt     = cin;
                    w_cnt_nxt   = '0;
                    w_sr_nxt    = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = C_RUN;
                end else begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = C_IDLE;
                end
            end
            C_RUN: begin
                w_sa_nxt  = r_sa >> 1;
                w_sb_nxt  = r_sb >> 1;
                w_sr_nxt  = w_sr_shift;
                w_c_nxt   = w_co;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == C_LAST) begin
                    w_sum_nxt   = w_sr_shift;
                    w_cout_nxt  = w_co;
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = C_DONE;
                end
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = C_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
